// File: rtl/duty_cycle_meter.sv
// Measures period and high time of an asynchronous waveform in CLK cycles and
// derives the integer duty cycle in percent with a 7-step restoring divider.
`timescale 1ns/1ps
module duty_cycle_meter #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam int unsigned DIV_W = CNT_W + 7;
  localparam int unsigned Q_W   = 7;
  localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

  typedef enum logic {IDLE, MEAS} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] hold_p;
  logic [CNT_W-1:0] hold_h;
  logic [DIV_W-1:0] div_rem;
  logic [DIV_W-1:0] div_dsh;
  logic [Q_W-2:0]   div_q;
  logic [2:0]       div_iter;
  logic             div_busy;

  logic rise;
  logic div_ge;
  logic cnt_full;

  assign rise     = s2 & ~s3;
  assign div_ge   = (div_rem >= div_dsh);
  assign cnt_full = (period_cnt == MAX_CNT);

  // Quotient is known to fit in 7 bits (H < P), so the divisor starts shifted
  // left by 6 and walks right one position per iteration.
  always_ff @(posedge CLK) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      hold_p     <= '0;
      hold_h     <= '0;
      div_rem    <= '0;
      div_dsh    <= '0;
      div_q      <= '0;
      div_iter   <= '0;
      div_busy   <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;

      if (!enable) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        overrun    <= 1'b0;
        div_busy   <= 1'b0;
        div_iter   <= '0;
      end else begin
        if (div_busy) begin
          div_iter <= div_iter + 3'd1;
          div_dsh  <= div_dsh >> 1;
          div_q    <= {div_q[Q_W-3:0], div_ge};
          if (div_ge) begin
            div_rem <= div_rem - div_dsh;
          end
          if (div_iter == 3'(Q_W - 1)) begin
            div_busy  <= 1'b0;
            period    <= hold_p;
            high_time <= hold_h;
            duty_pct  <= {div_q, div_ge};
            valid     <= 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (rise) begin
              state      <= MEAS;
              period_cnt <= CNT_W'(1);
              high_cnt   <= CNT_W'(1);
              stuck      <= 1'b0;
            end
          end
          MEAS: begin
            if (rise) begin
              period_cnt <= CNT_W'(1);
              high_cnt   <= CNT_W'(1);
              stuck      <= 1'b0;
              if (div_busy) begin
                overrun <= 1'b1;
              end else begin
                hold_p   <= period_cnt;
                hold_h   <= high_cnt;
                div_rem  <= DIV_W'(high_cnt) * DIV_W'(100);
                div_dsh  <= DIV_W'(period_cnt) << (Q_W - 1);
                div_q    <= '0;
                div_iter <= '0;
                div_busy <= 1'b1;
              end
            end else if (cnt_full) begin
              // No rise within MAX cycles: report the static level.
              state      <= IDLE;
              period_cnt <= '0;
              high_cnt   <= '0;
              period     <= '0;
              high_time  <= '0;
              duty_pct   <= s2 ? 7'd100 : 7'd0;
              stuck      <= 1'b1;
              valid      <= 1'b1;
            end else begin
              period_cnt <= period_cnt + CNT_W'(1);
              if (s2 && (high_cnt != MAX_CNT)) begin
                high_cnt <= high_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Directed testbench for duty_cycle_meter with hand-computed expectations.
`timescale 1ns/1ps
module tb_duty_cycle_meter;

  localparam int unsigned CNT_W = 10;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [6:0]       duty_pct;
  logic             valid;
  logic             stuck;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wave_t0 = 0;

  // Valid-pulse monitor; stats restart whenever a test bumps mon_epoch.
  int mon_epoch = 0;
  int m_epoch = -1;
  int v_n = 0;
  int v_first = 0;
  int v_last = 0;
  int v_imin = 0;
  int v_imax = 0;
  logic [CNT_W-1:0] v_period;
  logic [CNT_W-1:0] v_high;
  logic [6:0]       v_duty;
  logic             v_stuck;
  logic             v_overrun;

  duty_cycle_meter #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .duty_pct  (duty_pct),
    .valid     (valid),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      if (m_epoch != mon_epoch) begin
        m_epoch = mon_epoch;
        v_n     = 0;
        v_imin  = 1 << 30;
        v_imax  = 0;
      end
      if (v_n > 0) begin
        if (cyc - v_last < v_imin) v_imin = cyc - v_last;
        if (cyc - v_last > v_imax) v_imax = cyc - v_last;
      end else begin
        v_first = cyc;
      end
      v_last    = cyc;
      v_n       = v_n + 1;
      v_period  = period;
      v_high    = high_time;
      v_duty    = duty_pct;
      v_stuck   = stuck;
      v_overrun = overrun;
    end
  end

  function automatic int seen();
    return (m_epoch == mon_epoch) ? v_n : 0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic drive_wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) begin
        step(1);
        sig_in = 1'b1;
        if (r == 0 && i == 0) wave_t0 = cyc;
      end
      for (int i = 0; i < lo; i++) begin
        step(1);
        sig_in = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    step(1);
    reset  = 1'b1;
    sig_in = 1'b0;
    step(3);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (period !== 10'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
    checks++; if (high_time !== 10'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", high_time); end
    checks++; if (duty_pct !== 7'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty_pct); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %0b expected 0", stuck); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
  endtask

  task automatic test_period10();
    mon_epoch++;
    apply_reset();
    enable = 1'b1;
    drive_wave(3, 7, 6);
    step(12);
    checks++; if (seen() != 5) begin errors++; $display("FAIL p10_count: got %0d expected 5", seen()); end
    checks++; if (v_period !== 10'd10) begin errors++; $display("FAIL p10_period: got %0d expected 10", v_period); end
    checks++; if (v_high !== 10'd3) begin errors++; $display("FAIL p10_high: got %0d expected 3", v_high); end
    checks++; if (v_duty !== 7'd30) begin errors++; $display("FAIL p10_duty: got %0d expected 30", v_duty); end
    checks++; if (v_stuck !== 1'b0) begin errors++; $display("FAIL p10_stuck: got %0b expected 0", v_stuck); end
    checks++; if (v_overrun !== 1'b0) begin errors++; $display("FAIL p10_overrun: got %0b expected 0", v_overrun); end
    checks++; if (v_imin != 10 || v_imax != 10) begin errors++; $display("FAIL p10_interval: got %0d..%0d expected 10", v_imin, v_imax); end
  endtask

  task automatic test_overrun();
    mon_epoch++;
    apply_reset();
    enable = 1'b1;
    drive_wave(3, 3, 9);
    step(12);
    checks++; if (seen() != 4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", seen()); end
    checks++; if (v_period !== 10'd6) begin errors++; $display("FAIL ovr_period: got %0d expected 6", v_period); end
    checks++; if (v_high !== 10'd3) begin errors++; $display("FAIL ovr_high: got %0d expected 3", v_high); end
    checks++; if (v_duty !== 7'd50) begin errors++; $display("FAIL ovr_duty: got %0d expected 50", v_duty); end
    checks++; if (v_imin != 12 || v_imax != 12) begin errors++; $display("FAIL ovr_interval: got %0d..%0d expected 12", v_imin, v_imax); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
    checks++; if (period !== 10'd6) begin errors++; $display("FAIL ovr_hold_period: got %0d expected 6", period); end
    step(2);
  endtask

  task automatic test_enable_gap();
    mon_epoch++;
    apply_reset();
    enable = 1'b1;
    drive_wave(3, 4, 1);
    enable = 1'b0;
    drive_wave(3, 7, 3);
    step(1);
    checks++; if (seen() != 0) begin errors++; $display("FAIL gap_no_valid: got %0d expected 0", seen()); end
    enable = 1'b1;
    drive_wave(3, 7, 3);
    step(12);
    checks++; if (seen() != 2) begin errors++; $display("FAIL gap_count: got %0d expected 2", seen()); end
    checks++; if (v_first - wave_t0 != 20) begin errors++; $display("FAIL gap_latency: got %0d expected 20", v_first - wave_t0); end
    checks++; if (v_period !== 10'd10) begin errors++; $display("FAIL gap_period: got %0d expected 10", v_period); end
    checks++; if (v_high !== 10'd3) begin errors++; $display("FAIL gap_high: got %0d expected 3", v_high); end
    checks++; if (v_duty !== 7'd30) begin errors++; $display("FAIL gap_duty: got %0d expected 30", v_duty); end
  endtask

  task automatic test_reset_midflight();
    mon_epoch++;
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    drive_wave(3, 7, 1);
    drive_wave(3, 0, 1);
    step(1);
    sig_in = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(15);
    checks++; if (seen() != 0) begin errors++; $display("FAIL mid_no_valid: got %0d expected 0", seen()); end
    checks++; if (period !== 10'd0) begin errors++; $display("FAIL mid_period: got %0d expected 0", period); end
    checks++; if (high_time !== 10'd0) begin errors++; $display("FAIL mid_high: got %0d expected 0", high_time); end
    checks++; if (duty_pct !== 7'd0) begin errors++; $display("FAIL mid_duty: got %0d expected 0", duty_pct); end
    checks++; if (stuck !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_flags: got %0b%0b expected 00", stuck, overrun); end
    drive_wave(3, 7, 2);
    step(12);
    checks++; if (seen() != 1) begin errors++; $display("FAIL mid_resume_count: got %0d expected 1", seen()); end
    checks++; if (v_period !== 10'd10 || v_high !== 10'd3) begin errors++; $display("FAIL mid_resume_vals: got %0d/%0d expected 10/3", v_period, v_high); end
    checks++; if (v_duty !== 7'd30) begin errors++; $display("FAIL mid_resume_duty: got %0d expected 30", v_duty); end
  endtask

  task automatic test_stuck();
    mon_epoch++;
    apply_reset();
    enable = 1'b1;
    drive_wave(512, 511, 2);
    step(1);
    sig_in = 1'b1;
    step(30);
    checks++; if (seen() != 2) begin errors++; $display("FAIL max_count: got %0d expected 2", seen()); end
    checks++; if (v_period !== 10'd1023) begin errors++; $display("FAIL max_period: got %0d expected 1023", v_period); end
    checks++; if (v_high !== 10'd512) begin errors++; $display("FAIL max_high: got %0d expected 512", v_high); end
    checks++; if (v_duty !== 7'd50) begin errors++; $display("FAIL max_duty: got %0d expected 50", v_duty); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL max_stuck: got %0b expected 0", stuck); end
    step(1100);
    checks++; if (seen() != 3) begin errors++; $display("FAIL stuck_count: got %0d expected 3", seen()); end
    checks++; if (v_period !== 10'd0 || v_high !== 10'd0) begin errors++; $display("FAIL stuck_vals: got %0d/%0d expected 0/0", v_period, v_high); end
    checks++; if (v_duty !== 7'd100) begin errors++; $display("FAIL stuck_duty: got %0d expected 100", v_duty); end
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_flag: got %0b expected 1", stuck); end
    step(200);
    checks++; if (seen() != 3) begin errors++; $display("FAIL stuck_single: got %0d expected 3", seen()); end
    sig_in = 1'b0;
    step(5);
    drive_wave(3, 7, 3);
    step(12);
    checks++; if (seen() != 5) begin errors++; $display("FAIL unstuck_count: got %0d expected 5", seen()); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL unstuck_flag: got %0b expected 0", stuck); end
    checks++; if (period !== 10'd10 || duty_pct !== 7'd30) begin errors++; $display("FAIL unstuck_vals: got %0d/%0d expected 10/30", period, duty_pct); end
  endtask

  task automatic test_back_to_back();
    mon_epoch++;
    apply_reset();
    enable = 1'b1;
    drive_wave(1, 7, 6);
    step(12);
    checks++; if (seen() != 5) begin errors++; $display("FAIL p8_count: got %0d expected 5", seen()); end
    checks++; if (v_period !== 10'd8) begin errors++; $display("FAIL p8_period: got %0d expected 8", v_period); end
    checks++; if (v_high !== 10'd1) begin errors++; $display("FAIL p8_high: got %0d expected 1", v_high); end
    checks++; if (v_duty !== 7'd12) begin errors++; $display("FAIL p8_duty: got %0d expected 12", v_duty); end
    checks++; if (v_imin != 8 || v_imax != 8) begin errors++; $display("FAIL p8_interval: got %0d..%0d expected 8", v_imin, v_imax); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL p8_overrun: got %0b expected 0", overrun); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_period10();
    test_overrun();
    test_enable_gap();
    test_reset_midflight();
    test_stuck();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
